// File: rtl/dlfloat_pkg.sv
// Shared DLFloat definitions (1 sign, 6 exponent bias 31, 9 mantissa) and the MAC job sequencer state type.
package dlfloat_pkg;

  localparam int          DLF_W    = 16;
  localparam logic [15:0] DLF_ZERO = 16'h0000;
  localparam logic [15:0] DLF_ONE  = 16'h3E00;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } mac_state_e;

endpackage

// File: rtl/dlfloat_mac_seq.sv
// Sequences one dot-product job through the shared DLFloat MAC: clear, stream N pairs, drain, return result.
// Result is valid MAC_LAT+1 edges after the last pair is accepted; the result is held until res_ready_i is seen.
module dlfloat_mac_seq
  import dlfloat_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int LEN_W   = 8,
  parameter int MAC_LAT = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [LEN_W-1:0]  cmd_len_i,
  input  logic              op_valid_i,
  output logic              op_ready_o,
  input  logic [DATA_W-1:0] op_a_i,
  input  logic [DATA_W-1:0] op_b_i,
  output logic [DATA_W-1:0] mac_a_o,
  output logic [DATA_W-1:0] mac_b_o,
  output logic              mac_en_o,
  output logic              mac_clr_o,
  input  logic [DATA_W-1:0] mac_acc_i,
  output logic              res_valid_o,
  input  logic              res_ready_i,
  output logic [DATA_W-1:0] res_data_o,
  output logic              busy_o
);

  localparam int DRN_W = (MAC_LAT < 2) ? 1 : $clog2(MAC_LAT + 1);

  mac_state_e        state_q, state_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [DRN_W-1:0]  drain_q, drain_d;
  logic [DATA_W-1:0] mac_a_q, mac_a_d;
  logic [DATA_W-1:0] mac_b_q, mac_b_d;
  logic              mac_en_q, mac_en_d;
  logic              mac_clr_q, mac_clr_d;
  logic [DATA_W-1:0] res_data_q, res_data_d;

  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    drain_d    = drain_q;
    mac_a_d    = mac_a_q;
    mac_b_d    = mac_b_q;
    mac_en_d   = 1'b0;
    mac_clr_d  = 1'b0;
    res_data_d = res_data_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          rem_d = cmd_len_i;
          if (cmd_len_i == '0) begin
            res_data_d = DATA_W'(DLF_ZERO);
            state_d    = ST_DONE;
          end else begin
            mac_clr_d = 1'b1;
            state_d   = ST_CLEAR;
          end
        end
      end
      ST_CLEAR: state_d = ST_STREAM;
      ST_STREAM: begin
        if (op_valid_i) begin
          mac_a_d  = op_a_i;
          mac_b_d  = op_b_i;
          mac_en_d = 1'b1;
          rem_d    = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) begin
            drain_d = DRN_W'(MAC_LAT);
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        // Countdown starts while mac_en for the last pair is still registered, hence capture at zero.
        if (drain_q == '0) begin
          res_data_d = mac_acc_i;
          state_d    = ST_DONE;
        end else begin
          drain_d = drain_q - DRN_W'(1);
        end
      end
      ST_DONE: begin
        if (res_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      rem_q      <= '0;
      drain_q    <= '0;
      mac_a_q    <= '0;
      mac_b_q    <= '0;
      mac_en_q   <= 1'b0;
      mac_clr_q  <= 1'b0;
      res_data_q <= '0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      drain_q    <= drain_d;
      mac_a_q    <= mac_a_d;
      mac_b_q    <= mac_b_d;
      mac_en_q   <= mac_en_d;
      mac_clr_q  <= mac_clr_d;
      res_data_q <= res_data_d;
    end
  end

  assign cmd_ready_o = (state_q == ST_IDLE);
  assign op_ready_o  = (state_q == ST_STREAM);
  assign res_valid_o = (state_q == ST_DONE);
  assign busy_o      = (state_q != ST_IDLE);
  assign mac_a_o     = mac_a_q;
  assign mac_b_o     = mac_b_q;
  assign mac_en_o    = mac_en_q;
  assign mac_clr_o   = mac_clr_q;
  assign res_data_o  = res_data_q;

endmodule

// File: tb/tb_dlfloat_mac_seq.sv
// Bench for dlfloat_mac_seq: behavioural DLFloat MAC (latency 3) plus table-driven, hand-written and random jobs.
module tb_dlfloat_mac_seq;
  import dlfloat_pkg::*;

  localparam int DW  = 16;
  localparam int LW  = 8;
  localparam int LAT = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready_o;
  logic [LW-1:0] cmd_len = '0;
  logic          op_valid = 1'b0;
  logic          op_ready_o;
  logic [DW-1:0] op_a = '0, op_b = '0;
  logic [DW-1:0] mac_a_o, mac_b_o;
  logic          mac_en_o, mac_clr_o;
  logic [DW-1:0] mac_acc;
  logic          res_valid_o;
  logic          res_ready = 1'b0;
  logic [DW-1:0] res_data_o;
  logic          busy_o;

  always #5 clk = ~clk;

  dlfloat_mac_seq #(.DATA_W(DW), .LEN_W(LW), .MAC_LAT(LAT)) dut (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready_o), .cmd_len_i(cmd_len),
    .op_valid_i(op_valid), .op_ready_o(op_ready_o), .op_a_i(op_a), .op_b_i(op_b),
    .mac_a_o(mac_a_o), .mac_b_o(mac_b_o), .mac_en_o(mac_en_o), .mac_clr_o(mac_clr_o),
    .mac_acc_i(mac_acc),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready), .res_data_o(res_data_o),
    .busy_o(busy_o)
  );

  function automatic real dlf2r(input logic [15:0] w);
    real r;
    int  e;
    int  m;
    if (w[14:0] == 15'd0) return 0.0;
    m = int'(w[8:0]);
    r = 1.0 + m / 512.0;
    e = int'(w[14:9]) - 31;
    while (e > 0) begin r = r * 2.0; e--; end
    while (e < 0) begin r = r / 2.0; e++; end
    return w[15] ? -r : r;
  endfunction

  function automatic logic [15:0] r2dlf(input real v);
    logic       s;
    int         e;
    int         m;
    logic [5:0] e6;
    logic [8:0] m9;
    if (v == 0.0) return 16'h0000;
    s = (v < 0.0);
    if (s) v = -v;
    e = 31;
    while (v >= 2.0) begin v = v / 2.0; e++; end
    while (v < 1.0) begin v = v * 2.0; e--; end
    m  = int'((v - 1.0) * 512.0);
    e6 = e[5:0];
    m9 = m[8:0];
    return {s, e6, m9};
  endfunction

  // Datapath model: accumulator starts dirty and is not touched by rst, so only mac_clr can clean it.
  real  acc_r = 7.0;
  real  p1_r = 0.0, p2_r = 0.0;
  logic v1 = 1'b0, v2 = 1'b0;
  always @(posedge clk) begin
    if (mac_clr_o) begin
      acc_r <= 0.0;
      v1    <= 1'b0;
      v2    <= 1'b0;
    end else begin
      v1   <= mac_en_o;
      p1_r <= dlf2r(mac_a_o) * dlf2r(mac_b_o);
      v2   <= v1;
      p2_r <= p1_r;
      if (v2) acc_r <= acc_r + p2_r;
    end
  end
  always_comb mac_acc = r2dlf(acc_r);

  int n_clr = 0, n_en = 0;
  bit overlap = 1'b0;
  always @(negedge clk) begin
    if (mac_clr_o) n_clr <= n_clr + 1;
    if (mac_en_o) n_en <= n_en + 1;
    if (mac_en_o && mac_clr_o) overlap <= 1'b1;
  end

  int checks = 0, errors = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [DW-1:0] ja [256];
  logic [DW-1:0] jb [256];

  task automatic run_job(input int len, input logic [15:0] exp_res, input int hold,
                         input bit rdy_high, input string tag);
    int c0, e0, n, i, guard;
    logic [DW-1:0] held;
    res_ready = rdy_high;
    guard = 0;
    while (!cmd_ready_o && guard < 50) begin step(); guard++; end
    chk({tag, " cmd_ready"}, 32'(cmd_ready_o), 1);
    cmd_valid = 1'b1;
    cmd_len   = len[LW-1:0];
    c0 = n_clr;
    e0 = n_en;
    step();
    cmd_valid = 1'b0;
    chk({tag, " busy"}, 32'(busy_o), 1);
    if (len == 0) begin
      chk({tag, " len0 res_valid"}, 32'(res_valid_o), 1);
    end else begin
      chk({tag, " clr after cmd"}, 32'(mac_clr_o), 1);
      chk({tag, " op_ready in clear"}, 32'(op_ready_o), 0);
      step();
      chk({tag, " clr one cycle"}, 32'(mac_clr_o), 0);
      chk({tag, " op_ready stream"}, 32'(op_ready_o), 1);
      i = 0;
      guard = 0;
      while (i < len && guard < 4 * len + 40) begin
        op_valid = ($urandom_range(0, 3) != 0);
        op_a = ja[i];
        op_b = jb[i];
        if (op_valid && op_ready_o) begin
          step();
          i++;
          chk({tag, " mac_en pulse"}, 32'(mac_en_o), 1);
          chk({tag, " mac_a"}, 32'(mac_a_o), 32'(ja[i-1]));
          chk({tag, " mac_b"}, 32'(mac_b_o), 32'(jb[i-1]));
        end else begin
          step();
          if (i > 0) begin
            chk({tag, " bubble no en"}, 32'(mac_en_o), 0);
            chk({tag, " bubble hold a"}, 32'(mac_a_o), 32'(ja[i-1]));
          end
        end
        guard++;
      end
      op_valid = 1'b0;
      chk({tag, " pairs streamed"}, 32'(i), 32'(len));
      chk({tag, " op_ready after last"}, 32'(op_ready_o), 0);
      n = 0;
      while (!res_valid_o && n < 20) begin step(); n++; end
      chk({tag, " result latency"}, 32'(n), 32'(LAT + 1));
    end
    chk({tag, " res_valid"}, 32'(res_valid_o), 1);
    chk({tag, " res_data"}, 32'(res_data_o), 32'(exp_res));
    held = res_data_o;
    for (int k = 0; k < hold; k++) begin
      cmd_valid = k[0];
      cmd_len   = 8'd1;
      op_valid  = k[0];
      step();
      chk({tag, " hold data"}, 32'(res_data_o), 32'(held));
      chk({tag, " hold valid"}, 32'(res_valid_o), 1);
      chk({tag, " hold cmd_ready"}, 32'(cmd_ready_o), 0);
      chk({tag, " hold op_ready"}, 32'(op_ready_o), 0);
    end
    cmd_valid = 1'b0;
    op_valid  = 1'b0;
    res_ready = 1'b1;
    step();
    if (!rdy_high) res_ready = 1'b0;
    chk({tag, " res_valid drop"}, 32'(res_valid_o), 0);
    chk({tag, " idle cmd_ready"}, 32'(cmd_ready_o), 1);
    chk({tag, " idle busy"}, 32'(busy_o), 0);
    chk({tag, " clr count"}, 32'(n_clr - c0), (len != 0) ? 32'd1 : 32'd0);
    chk({tag, " en count"}, 32'(n_en - e0), 32'(len));
  endtask

  typedef struct {
    int          len;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp_res;
    int          hold;
    bit          rdy_high;
  } vec_t;

  vec_t vecs [8];

  initial begin
    real  sum;
    int   len, ka, kb;
    #500000;
    $display("FAIL global timeout");
    $fatal(1);
  end

  initial begin
    real sum;
    int  len, ka, kb;

    vecs[0] = '{1,   DLF_ONE, 16'h4000, 16'h4000, 0,  1'b0}; // 1.0*2.0
    vecs[1] = '{0,   16'h0000, 16'h0000, 16'h0000, 1, 1'b0};
    vecs[2] = '{4,   DLF_ONE, DLF_ONE,  16'h4200, 10, 1'b0}; // 4.0, long hold in DONE
    vecs[3] = '{2,   16'h4000, 16'h4000, 16'h4400, 0, 1'b1}; // 8.0, back-to-back
    vecs[4] = '{3,   16'hBE00, 16'h4000, 16'hC300, 0, 1'b1}; // -6.0
    vecs[5] = '{3,   16'h4000, 16'h4200, 16'h4700, 2, 1'b0}; // 24.0
    vecs[6] = '{5,   16'h3C00, 16'h4000, 16'h4280, 1, 1'b0}; // 5.0
    vecs[7] = '{255, DLF_ONE, DLF_ONE,  16'h4DFC, 0,  1'b0}; // 255.0, max length

    #12;
    chk("reset cmd_ready", 32'(cmd_ready_o), 1);
    chk("reset op_ready", 32'(op_ready_o), 0);
    chk("reset mac_en", 32'(mac_en_o), 0);
    chk("reset mac_clr", 32'(mac_clr_o), 0);
    chk("reset res_valid", 32'(res_valid_o), 0);
    chk("reset busy", 32'(busy_o), 0);
    chk("reset mac_a", 32'(mac_a_o), 0);
    chk("reset mac_b", 32'(mac_b_o), 0);
    chk("reset res_data", 32'(res_data_o), 0);
    step();
    rst = 1'b0;
    step();

    for (int v = 0; v < 8; v++) begin
      for (int p = 0; p < vecs[v].len; p++) begin
        ja[p] = vecs[v].a;
        jb[p] = vecs[v].b;
      end
      run_job(vecs[v].len, vecs[v].exp_res, vecs[v].hold, vecs[v].rdy_high,
              $sformatf("vec%0d", v));
    end
    res_ready = 1'b0;

    // Reset in the middle of a 5-pair job, after two pairs have gone in.
    for (int p = 0; p < 5; p++) begin ja[p] = DLF_ONE; jb[p] = 16'h4000; end
    cmd_valid = 1'b1;
    cmd_len   = 8'd5;
    step();
    cmd_valid = 1'b0;
    step();
    op_valid = 1'b1;
    op_a = ja[0];
    op_b = jb[0];
    step();
    step();
    op_valid = 1'b0;
    chk("midjob mac_en before rst", 32'(mac_en_o), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("async rst cmd_ready", 32'(cmd_ready_o), 1);
    chk("async rst op_ready", 32'(op_ready_o), 0);
    chk("async rst mac_en", 32'(mac_en_o), 0);
    chk("async rst busy", 32'(busy_o), 0);
    chk("async rst mac_a", 32'(mac_a_o), 0);
    chk("async rst res_valid", 32'(res_valid_o), 0);
    step();
    step();
    rst = 1'b0;
    step();
    ja[0] = DLF_ONE;
    jb[0] = 16'h4000;
    run_job(1, 16'h4000, 0, 1'b0, "after reset");

    // Random jobs with small integer operands, all sums exactly representable.
    for (int j = 0; j < 20; j++) begin
      len = $urandom_range(0, 8);
      sum = 0.0;
      for (int p = 0; p < len; p++) begin
        ka = $urandom_range(0, 14) - 7;
        kb = $urandom_range(0, 14) - 7;
        ja[p] = r2dlf(real'(ka));
        jb[p] = r2dlf(real'(kb));
        sum = sum + real'(ka * kb);
      end
      run_job(len, r2dlf(sum), $urandom_range(0, 3), 1'b0, $sformatf("rand%0d", j));
    end

    step();
    chk("mac_en/mac_clr overlap", 32'(overlap), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
